stg_mo_hs: RTL

Parametrised memory-operation pipeline stage, the successor to the fixed two-port, zero-wait memory stage. It issues loads and stores to one of NPORT memory ports using a per-port req/ack handshake, and supports variable wait states. While a transaction is outstanding it stalls upstream and emits bubbles downstream. It adds a flush input, a bounded-wait timeout and a fault report. It sits between the execute stage and the writeback stage.

---
 rtl/stg_mo_hs.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/stg_mo_hs.sv
// stg_mo_hs: memory-operation pipeline stage between execute and writeback.
// Issues loads/stores to one of NPORT memory ports with a req/ack handshake.
// While a transaction is outstanding it stalls upstream and emits bubbles.
// Also handles flush, a bounded-wait timeout and a fault report.
module stg_mo_hs #(
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 24,
  parameter int OPC_W    = 8,
  parameter int TGT_GP_W = 4,
  parameter int TGT_SR_W = 2,
  parameter int NPORT    = 2,
  parameter int MP_W     = 1,
  parameter int TIMEOUT  = 16,
  parameter int NOP_OPC  = 0
) (
  input  logic                     iw_clk,
  input  logic                     iw_rst,
  input  logic                     iw_valid,
  input  logic                     iw_flush,
  input  logic [ADDR_W-1:0]        iw_pc,
  input  logic [DATA_W-1:0]        iw_instr,
  input  logic [OPC_W-1:0]         iw_opc,
  input  logic                     iw_mem_ld,
  input  logic                     iw_mem_st,
  input  logic [MP_W-1:0]          iw_mem_mp,
  input  logic [ADDR_W-1:0]        iw_addr,
  input  logic [DATA_W-1:0]        iw_result,
  input  logic [TGT_GP_W-1:0]      iw_tgt_gp,
  input  logic                     iw_tgt_gp_we,
  input  logic [TGT_SR_W-1:0]      iw_tgt_sr,
  input  logic                     iw_tgt_sr_we,
  output logic                     ow_stall,
  output logic [NPORT-1:0]         ow_mem_req,
  output logic [NPORT-1:0]         ow_mem_we,
  output logic [NPORT*ADDR_W-1:0]  ow_mem_addr,
  output logic [NPORT*DATA_W-1:0]  ow_mem_wdata,
  input  logic [NPORT-1:0]         iw_mem_ack,
  input  logic [NPORT*DATA_W-1:0]  iw_mem_rdata,
  output logic                     ow_valid,
  output logic [ADDR_W-1:0]        ow_pc,
  output logic [DATA_W-1:0]        ow_instr,
  output logic [OPC_W-1:0]         ow_opc,
  output logic [TGT_GP_W-1:0]      ow_tgt_gp,
  output logic                     ow_tgt_gp_we,
  output logic [TGT_SR_W-1:0]      ow_tgt_sr,
  output logic                     ow_tgt_sr_we,
  output logic [DATA_W-1:0]        ow_result,
  output logic                     ow_fault,
  output logic [ADDR_W-1:0]        ow_fault_pc
);

  // Counter only needs to reach TIMEOUT-2: the abort fires on the clock
  // where it would step to TIMEOUT-1, so the request spans TIMEOUT cycles
  // counting the initial issue cycle in IDLE.
  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = (TIMEOUT > 1) ? TIMEOUT - 2 : 0;
  localparam logic [OPC_W-1:0] NOP = OPC_W'(NOP_OPC);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t               state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 kill_reg;

  // Captured instruction for the duration of an outstanding transaction
  logic [ADDR_W-1:0]    hold_pc_reg;
  logic [DATA_W-1:0]    hold_instr_reg;
  logic [OPC_W-1:0]     hold_opc_reg;
  logic                 hold_ld_reg;
  logic                 hold_st_reg;
  logic [MP_W-1:0]      hold_mp_reg;
  logic [ADDR_W-1:0]    hold_addr_reg;
  logic [DATA_W-1:0]    hold_result_reg;
  logic [TGT_GP_W-1:0]  hold_gp_reg;
  logic                 hold_gp_we_reg;
  logic [TGT_SR_W-1:0]  hold_sr_reg;
  logic                 hold_sr_we_reg;

  logic                 in_wait;
  logic                 is_mem;
  logic                 port_ok;
  logic                 issue;
  logic                 req_on;
  logic [MP_W-1:0]      cur_mp;
  logic                 cur_st;
  logic [ADDR_W-1:0]    cur_addr;
  logic [DATA_W-1:0]    cur_wdata;
  logic [NPORT-1:0]     port_hit;
  logic                 ack_hit;
  logic                 to_hit;
  logic [DATA_W-1:0]    rdata_sel;

  assign in_wait  = (state_reg == WAIT);
  assign ow_stall = in_wait;

  assign is_mem  = iw_valid & (iw_mem_ld | iw_mem_st) & ~iw_flush;
  assign port_ok = (int'(iw_mem_mp) < NPORT);
  assign issue   = ~in_wait & is_mem & port_ok;
  assign req_on  = issue | in_wait;

  // In WAIT the bus is driven from the hold registers, in IDLE from the input
  assign cur_mp    = in_wait ? hold_mp_reg     : iw_mem_mp;
  assign cur_st    = in_wait ? hold_st_reg     : iw_mem_st;
  assign cur_addr  = in_wait ? hold_addr_reg   : iw_addr;
  assign cur_wdata = in_wait ? hold_result_reg : iw_result;

  // Per-port drive: only the selected port sees non-zero fields
  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    assign port_hit[gi]                       = req_on && (int'(cur_mp) == gi);
    assign ow_mem_req[gi]                     = port_hit[gi];
    assign ow_mem_we[gi]                      = port_hit[gi] & cur_st;
    assign ow_mem_addr[gi*ADDR_W +: ADDR_W]   = port_hit[gi] ? cur_addr  : '0;
    assign ow_mem_wdata[gi*DATA_W +: DATA_W]  = port_hit[gi] ? cur_wdata : '0;
  end

  // An ack only counts on the port currently being requested
  assign ack_hit = |(iw_mem_ack & port_hit);

  // Read-data mux for the active port
  always_comb begin
    rdata_sel = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (int'(cur_mp) == p) rdata_sel = iw_mem_rdata[p*DATA_W +: DATA_W];
    end
  end

  if (TIMEOUT != 0) begin : g_to
    assign to_hit = in_wait & ~ack_hit & (cnt_reg >= CNT_W'(TO_LAST));
  end else begin : g_no_to
    assign to_hit = 1'b0;
  end

  // FSM, hold registers and registered outputs
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      kill_reg        <= 1'b0;
      hold_pc_reg     <= '0;
      hold_instr_reg  <= '0;
      hold_opc_reg    <= '0;
      hold_ld_reg     <= 1'b0;
      hold_st_reg     <= 1'b0;
      hold_mp_reg     <= '0;
      hold_addr_reg   <= '0;
      hold_result_reg <= '0;
      hold_gp_reg     <= '0;
      hold_gp_we_reg  <= 1'b0;
      hold_sr_reg     <= '0;
      hold_sr_we_reg  <= 1'b0;
      ow_valid        <= 1'b0;
      ow_pc           <= '0;
      ow_instr        <= '0;
      ow_opc          <= NOP;
      ow_tgt_gp       <= '0;
      ow_tgt_gp_we    <= 1'b0;
      ow_tgt_sr       <= '0;
      ow_tgt_sr_we    <= 1'b0;
      ow_result       <= '0;
      ow_fault        <= 1'b0;
      ow_fault_pc     <= '0;
    end else begin
      ow_fault <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg  <= '0;
          kill_reg <= 1'b0;
          if (!iw_valid || iw_flush) begin
            ow_valid     <= 1'b0;
            ow_tgt_gp_we <= 1'b0;
            ow_tgt_sr_we <= 1'b0;
            ow_opc       <= NOP;
          end else if (is_mem && !port_ok) begin
            ow_valid     <= 1'b0;
            ow_tgt_gp_we <= 1'b0;
            ow_tgt_sr_we <= 1'b0;
            ow_opc       <= NOP;
            ow_fault     <= 1'b1;
            ow_fault_pc  <= iw_pc;
          end else if (is_mem && !ack_hit) begin
            hold_pc_reg     <= iw_pc;
            hold_instr_reg  <= iw_instr;
            hold_opc_reg    <= iw_opc;
            hold_ld_reg     <= iw_mem_ld;
            hold_st_reg     <= iw_mem_st;
            hold_mp_reg     <= iw_mem_mp;
            hold_addr_reg   <= iw_addr;
            hold_result_reg <= iw_result;
            hold_gp_reg     <= iw_tgt_gp;
            hold_gp_we_reg  <= iw_tgt_gp_we;
            hold_sr_reg     <= iw_tgt_sr;
            hold_sr_we_reg  <= iw_tgt_sr_we;
            ow_valid        <= 1'b0;
            ow_tgt_gp_we    <= 1'b0;
            ow_tgt_sr_we    <= 1'b0;
            ow_opc          <= NOP;
            state_reg       <= WAIT;
          end else begin
            // Non-memory instruction, or zero-wait memory completion
            ow_valid     <= 1'b1;
            ow_pc        <= iw_pc;
            ow_instr     <= iw_instr;
            ow_opc       <= iw_opc;
            ow_tgt_gp    <= iw_tgt_gp;
            ow_tgt_gp_we <= iw_tgt_gp_we;
            ow_tgt_sr    <= iw_tgt_sr;
            ow_tgt_sr_we <= iw_tgt_sr_we;
            ow_result    <= (is_mem && iw_mem_ld) ? rdata_sel : iw_result;
          end
        end
        WAIT: begin
          if (iw_flush) kill_reg <= 1'b1;
          if (ack_hit) begin
            state_reg <= IDLE;
            if (kill_reg || iw_flush) begin
              // Transaction finished on the bus but its writeback is dropped
              ow_valid     <= 1'b0;
              ow_tgt_gp_we <= 1'b0;
              ow_tgt_sr_we <= 1'b0;
              ow_opc       <= NOP;
            end else begin
              ow_valid     <= 1'b1;
              ow_pc        <= hold_pc_reg;
              ow_instr     <= hold_instr_reg;
              ow_opc       <= hold_opc_reg;
              ow_tgt_gp    <= hold_gp_reg;
              ow_tgt_gp_we <= hold_gp_we_reg;
              ow_tgt_sr    <= hold_sr_reg;
              ow_tgt_sr_we <= hold_sr_we_reg;
              ow_result    <= hold_ld_reg ? rdata_sel : hold_result_reg;
            end
          end else if (to_hit) begin
            state_reg    <= IDLE;
            ow_valid     <= 1'b0;
            ow_tgt_gp_we <= 1'b0;
            ow_tgt_sr_we <= 1'b0;
            ow_opc       <= NOP;
            ow_fault     <= 1'b1;
            ow_fault_pc  <= hold_pc_reg;
          end else begin
            ow_valid     <= 1'b0;
            ow_tgt_gp_we <= 1'b0;
            ow_tgt_sr_we <= 1'b0;
            ow_opc       <= NOP;
            cnt_reg      <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
